mdu: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Consumes the two GPR read-port values (rs -> a, rt -> b) that the register file produces.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Exposes HI/LO for MFHI/MFLO, and a busy flag that the hazard logic uses to stall dependent MD instructions.

---
 rtl/mdu_if.sv | 13 +
 rtl/mdu.sv | 109 ++++++++++
 tb/tb_mdu.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - issue/result bundle between the MIPS datapath and the multiply/divide unit
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt_q, cnt_n;
  logic [31:0]   hi_q, hi_n, lo_q, lo_n;
  logic [31:0]   a_q, a_n, b_q, b_n;
  logic [2:0]    op_q, op_n;

  logic [63:0]   ma, mb, prod;
  logic          is_signed, neg_a, neg_b, is_div, div_zero;
  logic [31:0]   ua, ub, ub_safe, uq, ur, dq, dr;

  // Result datapath works only from latched operands, so a/b may change while busy.
  always_comb begin
    ma        = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    mb        = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod      = ma * mb;
    is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    is_signed = (op_q == OP_DIV);
    neg_a     = is_signed & a_q[31];
    neg_b     = is_signed & b_q[31];
    ua        = neg_a ? -a_q : a_q;
    ub        = neg_b ? -b_q : b_q;
    div_zero  = (b_q == 32'd0);
    // Keep the divider free of X when b=0; the result is discarded in that case.
    ub_safe   = div_zero ? 32'd1 : ub;
    uq        = ua / ub_safe;
    ur        = ua % ub_safe;
    dq        = (neg_a ^ neg_b) ? -uq : uq;
    dr        = neg_a ? -ur : ur;
  end

  always_comb begin
    cnt_n = cnt_q;
    hi_n  = hi_q;
    lo_n  = lo_q;
    a_n   = a_q;
    b_n   = b_q;
    op_n  = op_q;
    if (cnt_q != '0) begin
      cnt_n = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        if (!is_div) begin
          hi_n = prod[63:32];
          lo_n = prod[31:0];
        end else if (!div_zero) begin
          hi_n = dr;
          lo_n = dq;
        end
      end
    end else if (bus.start) begin
      case (bus.op)
        OP_MULT, OP_MULTU: begin
          a_n   = bus.a;
          b_n   = bus.b;
          op_n  = bus.op;
          cnt_n = CW'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          a_n   = bus.a;
          b_n   = bus.b;
          op_n  = bus.op;
          cnt_n = CW'(DIV_CYCLES);
        end
        OP_MTHI: hi_n = bus.a;
        OP_MTLO: lo_n = bus.a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      cnt_q <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      a_q   <= a_n;
      b_q   <= b_n;
      op_q  <= op_n;
    end
  end

  assign bus.busy = (cnt_q != '0);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for the multiply/divide unit
module tb_mdu;
  logic clk;
  logic rst;
  int   tests;
  int   errors;

  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'd0;
  endtask

  // Counts negedges with busy high; bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    drive(op, a, b);
    wait_idle(n);
  endtask

  task automatic test_reset;
    tests++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want %h", bus.hi, 32'h0); end
    tests++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want %h", bus.lo, 32'h0); end
    tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    drive(3'd5, 32'h12345678, 32'h0);
    tests++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi: got %h want %h", bus.hi, 32'h12345678); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rst_after_mthi_hi: got %h want %h", bus.hi, 32'h0); end
    tests++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rst_after_mthi_lo: got %h want %h", bus.lo, 32'h0); end
    tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_after_mthi_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_mult;
    int n;
    run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, n);
    tests++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    tests++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); end
    tests++; if (bus.lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo: got %h want %h", bus.lo, 32'hFFFFFFFE); end
    run_op(3'd2, 32'hFFFFFFFF, 32'h00000002, n);
    tests++; if (n != 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
    tests++; if (bus.hi !== 32'h00000001) begin errors++; $display("FAIL multu_hi: got %h want %h", bus.hi, 32'h1); end
    tests++; if (bus.lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo: got %h want %h", bus.lo, 32'hFFFFFFFE); end
  endtask

  task automatic test_div;
    int n;
    run_op(3'd3, 32'hFFFFFFF9, 32'h00000002, n);
    tests++; if (n != 10) begin errors++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
    tests++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want %h", bus.lo, 32'hFFFFFFFD); end
    tests++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want %h", bus.hi, 32'hFFFFFFFF); end
    run_op(3'd4, 32'hFFFFFFF9, 32'h00000002, n);
    tests++; if (bus.lo !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu_lo: got %h want %h", bus.lo, 32'h7FFFFFFC); end
    tests++; if (bus.hi !== 32'h00000001) begin errors++; $display("FAIL divu_hi: got %h want %h", bus.hi, 32'h1); end
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, n);
    tests++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h want %h", bus.lo, 32'h80000000); end
    tests++; if (bus.hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi: got %h want %h", bus.hi, 32'h0); end
  endtask

  task automatic test_div_zero;
    int n;
    drive(3'd5, 32'hAAAA0000, 32'h0);
    drive(3'd6, 32'h0000BBBB, 32'h0);
    run_op(3'd4, 32'h00000007, 32'h00000000, n);
    tests++; if (n != 10) begin errors++; $display("FAIL divz_busy_cycles: got %0d want 10", n); end
    tests++; if (bus.hi !== 32'hAAAA0000) begin errors++; $display("FAIL divz_hi: got %h want %h", bus.hi, 32'hAAAA0000); end
    tests++; if (bus.lo !== 32'h0000BBBB) begin errors++; $display("FAIL divz_lo: got %h want %h", bus.lo, 32'h0000BBBB); end
  endtask

  task automatic test_ignore_busy;
    int n;
    drive(3'd1, 32'd3, 32'd4);
    bus.start = 1'b1;
    bus.op    = 3'd6;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'h55555555;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'd0;
    tests++; if (bus.lo === 32'hDEADBEEF) begin errors++; $display("FAIL ignore_mtlo_during_busy: got %h want not %h", bus.lo, 32'hDEADBEEF); end
    wait_idle(n);
    tests++; if (n != 4) begin errors++; $display("FAIL ignore_busy_cycles: got %0d want 4", n); end
    tests++; if (bus.lo !== 32'd12) begin errors++; $display("FAIL ignore_lo: got %h want %h", bus.lo, 32'd12); end
    tests++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL ignore_hi: got %h want %h", bus.hi, 32'd0); end
  endtask

  task automatic test_back_to_back;
    int n;
    // MTLO held with start=1 across the completion edge must land one edge later.
    drive(3'd2, 32'd2, 32'd3);
    bus.start = 1'b1;
    bus.op    = 3'd6;
    bus.a     = 32'h00000077;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    tests++; if (bus.lo !== 32'd6) begin errors++; $display("FAIL b2b_completion_lo: got %h want %h", bus.lo, 32'd6); end
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'd0;
    tests++; if (bus.lo !== 32'h00000077) begin errors++; $display("FAIL b2b_next_lo: got %h want %h", bus.lo, 32'h77); end
    tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_nop;
    drive(3'd0, 32'h00000099, 32'h1);
    drive(3'd7, 32'h00000099, 32'h1);
    tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nop_busy: got %b want 0", bus.busy); end
    tests++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL nop_hi: got %h want %h", bus.hi, 32'd0); end
    tests++; if (bus.lo !== 32'h00000077) begin errors++; $display("FAIL nop_lo: got %h want %h", bus.lo, 32'h77); end
  endtask

  task automatic test_reset_mid;
    drive(3'd5, 32'h00005555, 32'h0);
    drive(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    tests++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h want %h", bus.hi, 32'd0); end
    tests++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h want %h", bus.lo, 32'd0); end
    repeat (15) @(negedge clk);
    tests++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("FAIL rstmid_no_writeback: got hi=%h lo=%h want 0/0", bus.hi, bus.lo); end
  endtask

  initial begin
    tests     = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_ignore_busy;
    test_back_to_back;
    test_nop;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
